// File: rtl/sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_rom_arbiter
//
// Shares a single synchronous sprite ROM among N_REQ pixel-layer requesters
// (0 = frog, 1 = car, 2 = road). A round-robin grant drives a registered ROM
// address, and a one-hot tag travels alongside the read. The ROM word is handed
// back to the winning requester after a fixed 1 + ROM_LAT cycles.
//
// Ports
//   CLK        system / pixel clock
//   RST_N      synchronous active-low reset
//   flush      drop every in-flight read; no grant in this cycle
//   req_valid  per-requester read request
//   req_addr   packed request addresses; requester i uses [i*ADDR_W +: ADDR_W]
//   req_ready  one-hot grant (combinational)
//   rom_en     ROM read enable (registered)
//   rom_addr   ROM address (registered)
//   rom_data   ROM read data, valid ROM_LAT cycles after rom_addr
//   rsp_valid  one-hot response tag (registered)
//   rsp_data   rom_data while any rsp_valid bit is set, else 0
// -----------------------------------------------------------------------------
module sprite_rom_arbiter #(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 9,
  parameter int ROM_LAT = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]               rr_ptr_reg;
  logic [PTR_W-1:0]               rr_ptr_next;
  logic                           rom_en_reg;
  logic [ADDR_W-1:0]              rom_addr_reg;
  // Stage 0 lines up with rom_addr; stage ROM_LAT lines up with rom_data.
  logic [ROM_LAT:0][N_REQ-1:0]    tag_reg;

  logic                           grant_any;
  logic [PTR_W-1:0]               grant_idx;
  logic [ADDR_W-1:0]              grant_addr;

  // Round-robin search starting at rr_ptr_reg. Only the first valid
  // candidate in search order is taken.
  always_comb begin
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = (int'(rr_ptr_reg) + off) % N_REQ;
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(cand);
      end
    end
    // Flush and reset both suppress the grant so that nothing is accepted.
    if (flush || !RST_N) begin
      grant_any = 1'b0;
    end
  end

  assign rr_ptr_next = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign grant_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_any && (grant_idx == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rr_ptr_reg   <= '0;
      rom_en_reg   <= 1'b0;
      rom_addr_reg <= '0;
      tag_reg      <= '0;
    end else begin
      // A flush empties the whole tag pipeline. Stage 0 is already zero
      // because grant_any is suppressed during flush.
      for (int k = ROM_LAT; k >= 1; k--) begin
        tag_reg[k] <= flush ? '0 : tag_reg[k-1];
      end
      tag_reg[0] <= req_ready;
      rom_en_reg <= grant_any;
      if (grant_any) begin
        rr_ptr_reg   <= rr_ptr_next;
        rom_addr_reg <= grant_addr;
      end
    end
  end

  assign rom_en    = rom_en_reg;
  assign rom_addr  = rom_addr_reg;
  assign rsp_valid = tag_reg[ROM_LAT];
  assign rsp_data  = (|rsp_valid) ? rom_data : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sprite_rom_arbiter
//
// Drives a ROM_LAT=1 instance through directed and random steps. A queue-based
// model of granted reads predicts every output. A second instance with
// ROM_LAT=3 covers the longer latency and reset discard.
// -----------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

  localparam int N    = 3;
  localparam int AW   = 11;
  localparam int DW   = 9;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- ROM_LAT = 1 instance ----------------
  logic            RST_N, flush;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic            rom_en;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data, rsp_data;
  logic [AW-1:0]   rom_pipe [0:LAT-1];

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
    .CLK(CLK), .RST_N(RST_N), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  // Synchronous ROM whose word is addr[8:0].
  always @(posedge CLK) begin
    rom_pipe[0] <= rom_addr;
    for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_data = rom_pipe[LAT-1][DW-1:0];

  // ---------------- ROM_LAT = 3 instance ----------------
  logic            RST_N3, flush3;
  logic [N-1:0]    req_valid3, req_ready3, rsp_valid3;
  logic [N*AW-1:0] req_addr3;
  logic            rom_en3;
  logic [AW-1:0]   rom_addr3;
  logic [DW-1:0]   rom_data3, rsp_data3;
  logic [AW-1:0]   rom_pipe3 [0:LAT3-1];

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT3)) dut3 (
    .CLK(CLK), .RST_N(RST_N3), .flush(flush3),
    .req_valid(req_valid3), .req_addr(req_addr3), .req_ready(req_ready3),
    .rom_en(rom_en3), .rom_addr(rom_addr3), .rom_data(rom_data3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3)
  );

  always @(posedge CLK) begin
    rom_pipe3[0] <= rom_addr3;
    for (int k = 1; k < LAT3; k++) rom_pipe3[k] <= rom_pipe3[k-1];
  end
  assign rom_data3 = rom_pipe3[LAT3-1][DW-1:0];

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    logic [N-1:0]  tag;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          pend_q[$];
  int            cyc;
  int            ptr_m;
  logic          exp_en;
  logic [AW-1:0] exp_addr;
  logic [N-1:0]  last_rdy, last_rv;
  logic [DW-1:0] last_rd;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle on the LAT=1 instance: drive, check against the model,
  // then advance the model across the clock edge.
  task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                      input logic fl, input logic rn);
    int            g;
    int            c;
    logic [N-1:0]  exp_rdy, exp_rv;
    logic [DW-1:0] exp_rd;
    req_valid = v; req_addr = a; flush = fl; RST_N = rn;
    #1;
    g = -1;
    if (rn && !fl) begin
      for (int off = 0; off < N; off++) begin
        c = (ptr_m + off) % N;
        if (g < 0 && v[c]) g = c;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_rv = '0; exp_rd = '0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      exp_rv = pend_q[0].tag;
      exp_rd = pend_q[0].data;
      void'(pend_q.pop_front());
    end
    last_rdy = req_ready; last_rv = rsp_valid; last_rd = rsp_data;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rom_en",    32'(rom_en),    32'(exp_en));
    chk("rom_addr",  32'(rom_addr),  32'(exp_addr));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("rsp_data",  32'(rsp_data),  32'(exp_rd));
    if (!rn) begin
      ptr_m = 0; exp_en = 1'b0; exp_addr = '0; pend_q.delete();
    end else begin
      if (fl) pend_q.delete();
      if (g >= 0) begin
        ptr_m    = (g + 1) % N;
        exp_en   = 1'b1;
        exp_addr = a[g*AW +: AW];
        pend_q.push_back('{cyc + 1 + LAT, exp_rdy, exp_addr[DW-1:0]});
      end else begin
        exp_en = 1'b0;
      end
    end
    @(posedge CLK); #1;
    cyc++;
  endtask

  function automatic logic [N*AW-1:0] pack3(input logic [AW-1:0] a0,
                                            input logic [AW-1:0] a1,
                                            input logic [AW-1:0] a2);
    return {a2, a1, a0};
  endfunction

  initial begin
    logic [N*AW-1:0] all_a;
    logic [N-1:0]    oh;
    logic [63:0]     rnd;

    cyc = 0;
    req_valid = '0; req_addr = '0; flush = 1'b0; RST_N = 1'b0;
    req_valid3 = '0; req_addr3 = '0; flush3 = 1'b0; RST_N3 = 1'b0;
    @(posedge CLK); #1;
    ptr_m = 0; exp_en = 1'b0; exp_addr = '0;

    // Reset held with every requester asking.
    all_a = pack3(11'h0A1, 11'h1B2, 11'h2C3);
    for (int i = 0; i < 3; i++) step(3'b111, all_a, 1'b0, 1'b0);

    // Round robin: nine cycles with all three valid, starting at requester 0.
    for (int i = 0; i < 9; i++) begin
      step(3'b111, all_a, 1'b0, 1'b1);
      oh = '0; oh[i % N] = 1'b1;
      chk("rr_grant", 32'(last_rdy), 32'(oh));
    end
    for (int i = 0; i < 3; i++) step(3'b000, all_a, 1'b0, 1'b1);

    // Single car request at 0x123.
    step(3'b010, pack3(11'h000, 11'h123, 11'h000), 1'b0, 1'b1);
    chk("single_grant", 32'(last_rdy), 32'h2);
    step(3'b000, '0, 1'b0, 1'b1);
    step(3'b000, '0, 1'b0, 1'b1);
    chk("single_rsp_valid", 32'(last_rv), 32'h2);
    chk("single_rsp_data",  32'(last_rd), 32'h123);

    // Grant to 2, then only car: pointer 0 is skipped, then search starts at 2.
    step(3'b100, all_a, 1'b0, 1'b1);
    step(3'b010, all_a, 1'b0, 1'b1);
    chk("skip_grant", 32'(last_rdy), 32'h2);
    step(3'b011, all_a, 1'b0, 1'b1);
    chk("wrap_grant", 32'(last_rdy), 32'h1);
    for (int i = 0; i < 3; i++) step(3'b000, all_a, 1'b0, 1'b1);

    // Flush mid-stream.
    step(3'b001, all_a, 1'b0, 1'b1);
    step(3'b010, all_a, 1'b1, 1'b1);
    chk("flush_no_grant", 32'(last_rdy), 32'h0);
    step(3'b010, all_a, 1'b0, 1'b1);
    chk("flush_held_grant", 32'(last_rdy), 32'h2);
    chk("flush_rsp_cleared", 32'(last_rv), 32'h0);
    for (int i = 0; i < 3; i++) step(3'b000, all_a, 1'b0, 1'b1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom(), $urandom()};
      step(3'($urandom_range(0, 7)), rnd[N*AW-1:0],
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) != 0));
    end
    for (int i = 0; i < 4; i++) step(3'b000, '0, 1'b0, 1'b1);

    // ROM_LAT = 3 instance: single car grant, response four cycles later.
    @(posedge CLK); #1;
    RST_N3 = 1'b1;
    req_valid3 = 3'b010; req_addr3 = pack3(11'h000, 11'h2A5, 11'h000);
    #1;
    chk("lat3_grant", 32'(req_ready3), 32'h2);
    @(posedge CLK); #1;
    req_valid3 = 3'b000;
    chk("lat3_rom_en",   32'(rom_en3),   32'h1);
    chk("lat3_rom_addr", 32'(rom_addr3), 32'h2A5);
    for (int k = 1; k <= 5; k++) begin
      chk("lat3_rsp_valid", 32'(rsp_valid3), (k == 4) ? 32'h2 : 32'h0);
      chk("lat3_rsp_data",  32'(rsp_data3),  (k == 4) ? 32'h0A5 : 32'h0);
      @(posedge CLK); #1;
    end

    // ROM_LAT = 3 instance: reset pulse two cycles after a grant discards it.
    req_valid3 = 3'b001; req_addr3 = pack3(11'h155, 11'h000, 11'h000);
    #1;
    chk("lat3_grant2", 32'(req_ready3), 32'h1);
    @(posedge CLK); #1;
    req_valid3 = 3'b000;
    chk("lat3_rsp_none", 32'(rsp_valid3), 32'h0);
    @(posedge CLK); #1;
    RST_N3 = 1'b0; req_valid3 = 3'b111;
    #1;
    chk("lat3_rst_ready", 32'(req_ready3), 32'h0);
    chk("lat3_rsp_none", 32'(rsp_valid3), 32'h0);
    @(posedge CLK); #1;
    RST_N3 = 1'b1; req_valid3 = 3'b000;
    for (int k = 0; k < 4; k++) begin
      chk("lat3_rsp_none", 32'(rsp_valid3), 32'h0);
      chk("lat3_rst_rom_en", 32'(rom_en3), 32'h0);
      @(posedge CLK); #1;
    end
    req_valid3 = 3'b110;
    #1;
    chk("lat3_ptr_reset", 32'(req_ready3), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
